// File: rtl/iter_seq_ctrl.sv
// Sequencer for an external loadable up-counter: takes an N-iteration job, pulses step_en per
// iteration and reports completion/abort. Optional stall input enabled by STEP_STALL_EN.
module iter_seq_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] iter_cnt,
    input  logic             abort,
`ifdef STEP_STALL_EN
    input  logic             stall,
`endif
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             step_en,
    output logic [WIDTH-1:0] step_idx,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_aborted,
    output logic [WIDTH-1:0] done_steps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             aborted_q, aborted_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic             stall_w;
    logic             last_step;

`ifdef STEP_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // n_q is nonzero whenever RUN is reached, so n_q-1 never underflows here
    assign last_step = (cnt_value == n_q - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            aborted_q <= 1'b0;
            steps_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            aborted_q <= aborted_d;
            steps_q   <= steps_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        aborted_d   = aborted_q;
        steps_d     = steps_q;
        start_ready = 1'b0;
        cnt_load    = 1'b0;
        cnt_enable  = 1'b0;
        cnt_in      = '0;
        step_en     = 1'b0;
        step_idx    = '0;
        done_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    n_d = iter_cnt;
                    if (iter_cnt == '0) begin
                        state_d   = DONE;
                        aborted_d = 1'b0;
                        steps_d   = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                    steps_d   = '0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                step_idx = cnt_value;
                // abort outranks both the step and a stall; steps 0..cnt_value-1 are complete
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                    steps_d   = cnt_value;
                end else if (!stall_w) begin
                    step_en    = 1'b1;
                    cnt_enable = 1'b1;
                    if (last_step) begin
                        state_d   = DONE;
                        aborted_d = 1'b0;
                        steps_d   = n_q;
                    end
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done_aborted = aborted_q;
    assign done_steps   = steps_q;

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Directed bench for iter_seq_ctrl with a behavioural model of the external up-counter.
module tb_iter_seq_ctrl;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] iter_cnt = '0;
    logic             abort = 1'b0;
`ifdef STEP_STALL_EN
    logic             stall = 1'b0;
`endif
    logic             cnt_load;
    logic             cnt_enable;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_value = '0;
    logic             step_en;
    logic [WIDTH-1:0] step_idx;
    logic             busy;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic             done_aborted;
    logic [WIDTH-1:0] done_steps;

    int n_vec = 0;
    int n_err = 0;

    iter_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .iter_cnt     (iter_cnt),
        .abort        (abort),
`ifdef STEP_STALL_EN
        .stall        (stall),
`endif
        .cnt_load     (cnt_load),
        .cnt_enable   (cnt_enable),
        .cnt_in       (cnt_in),
        .cnt_value    (cnt_value),
        .step_en      (step_en),
        .step_idx     (step_idx),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_aborted (done_aborted),
        .done_steps   (done_steps)
    );

    always #5 clk = ~clk;

    // External loadable up-counter; it is not reset by rst_n
    always @(posedge clk) begin
        if (cnt_load)        cnt_value <= cnt_in;
        else if (cnt_enable) cnt_value <= cnt_value + WIDTH'(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort_at: -1 none, -2 during LOAD, k>=0 while step_idx==k
    task automatic run_job(input string tag, input int n, input int abort_at,
                           input int exp_steps, input int exp_ab, input int ready_delay);
        bit stopped;
        stopped     = 1'b0;
        start_valid = 1'b1;
        iter_cnt    = WIDTH'(n);
        #1;
        check({tag, ".start_ready"}, start_ready, 1);
        tick();
        start_valid = 1'b0;
        if (n != 0) begin
            check({tag, ".load"}, cnt_load, 1);
            check({tag, ".load_cnt_in"}, cnt_in, 0);
            check({tag, ".load_no_step"}, step_en, 0);
            if (abort_at == -2) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end else begin
                tick();
                for (int i = 0; i < n && !stopped; i++) begin
                    if (i == abort_at) begin
                        abort = 1'b1;
                        #1;
                        check({tag, ".abort_no_step"}, step_en, 0);
                        check({tag, ".abort_no_en"}, cnt_enable, 0);
                        tick();
                        abort   = 1'b0;
                        stopped = 1'b1;
                    end else begin
                        check({tag, ".step_en"}, step_en, 1);
                        check({tag, ".step_idx"}, step_idx, i);
                        check({tag, ".step_no_load"}, {cnt_load, cnt_enable}, 2'b01);
                        tick();
                    end
                end
            end
        end else begin
            check({tag, ".no_load"}, cnt_load, 0);
            check({tag, ".no_step"}, step_en, 0);
        end
        check({tag, ".done_valid"}, done_valid, 1);
        check({tag, ".done_steps"}, done_steps, exp_steps);
        check({tag, ".done_aborted"}, done_aborted, exp_ab);
        check({tag, ".done_no_start"}, start_ready, 0);
        if (n != 0) check({tag, ".counter"}, cnt_value, exp_steps);
        for (int h = 0; h < ready_delay; h++) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check({tag, ".hold_valid"}, done_valid, 1);
            check({tag, ".hold_steps"}, done_steps, exp_steps);
            check({tag, ".hold_aborted"}, done_aborted, exp_ab);
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check({tag, ".after_ready"}, start_ready, 1);
        check({tag, ".after_valid"}, done_valid, 0);
        check({tag, ".after_busy"}, busy, 0);
    endtask

    initial begin
        #2;
        check("rst.start_ready", start_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.done_valid", done_valid, 0);
        check("rst.done_steps", done_steps, 0);
        check("rst.done_aborted", done_aborted, 0);
        check("rst.outs", {cnt_load, cnt_enable, step_en}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort.busy", busy, 0);
        check("idle_abort.ready", start_ready, 1);

        run_job("n5", 5, -1, 5, 0, 0);
        run_job("n0", 0, -1, 0, 0, 1);
        run_job("n31", 31, -1, 31, 0, 3);
        run_job("ab3", 8, 3, 3, 1, 1);
        run_job("abld", 8, -2, 0, 1, 0);

        start_valid = 1'b1;
        iter_cnt    = WIDTH'(8);
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst.step_en", step_en, 0);
        check("midrst.busy", busy, 0);
        check("midrst.ready", start_ready, 1);
        check("midrst.outs", {cnt_load, cnt_enable, done_valid}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_job("n2", 2, -1, 2, 0, 0);

`ifdef STEP_STALL_EN
        start_valid = 1'b1;
        iter_cnt    = WIDTH'(4);
        tick();
        start_valid = 1'b0;
        check("stall.load", cnt_load, 1);
        tick();
        check("stall.idx0", step_idx, 0);
        tick();
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #1;
            check("stall.no_step", step_en, 0);
            check("stall.no_en", cnt_enable, 0);
            check("stall.idx_held", step_idx, 1);
            tick();
        end
        stall = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("stall.step_en", step_en, 1);
            check("stall.step_idx", step_idx, i);
            tick();
        end
        check("stall.done_valid", done_valid, 1);
        check("stall.done_steps", done_steps, 4);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("stall.after_ready", start_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
